sram_bus_master: RTL and testbench

Initiator for the team's single-port tristate SRAM bus (addr, shared inout data, cs/we/oe).
- Accepts read/write requests on a valid/ready host interface.
- Sequences the chip-select, write-enable and output-enable strobes.
- Owns bus turnaround and returns read data on a one-cycle response strobe.
- Sits between any host-side engine (DMA, CPU bridge) and the RAM macro.

---
 rtl/sram_bus_pkg.sv | 15 +
 rtl/sram_bus_io.sv | 34 +++
 rtl/sram_bus_master.sv | 135 +++++++++++++
 tb/tb_sram_bus_master.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types and default widths for the tristate SRAM bus master.
package sram_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_TURN = 3'd3,
    ST_VRD  = 3'd4
  } state_e;

endpackage

// File: rtl/sram_bus_io.sv
// Tristate data pad plus read-capture register for the SRAM bus.
// With SRAM_BUS_MASTER_VERIFY_EN the raw bus value is also exported for write-verify.
module sram_bus_io #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drive_en_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  input  logic                  cap_en_i,
`ifdef SRAM_BUS_MASTER_VERIFY_EN
  output logic [DATA_WIDTH-1:0] din_o,
`endif
  output logic [DATA_WIDTH-1:0] din_q_o,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  logic [DATA_WIDTH-1:0] din_q;

  assign ram_data = drive_en_i ? dout_i : {DATA_WIDTH{1'bz}};

`ifdef SRAM_BUS_MASTER_VERIFY_EN
  assign din_o = ram_data;
`endif

  // Holds the last read word until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           din_q <= '0;
    else if (cap_en_i) din_q <= ram_data;
  end

  assign din_q_o = din_q;

endmodule

// File: rtl/sram_bus_master.sv
// Valid/ready host to single-port tristate SRAM initiator with turnaround handling.
// Optional write-verify read-back enabled by SRAM_BUS_MASTER_VERIFY_EN.
module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  wr_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  ready_st;
  logic                  accept;
  logic                  from_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    ready_st = 1'b1;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_oe   = 1'b0;
    case (state_q)
      ST_WR: begin
        ram_cs = 1'b1;
        ram_we = 1'b1;
`ifdef SRAM_BUS_MASTER_VERIFY_EN
        ready_st = 1'b0;
`endif
      end
      ST_RD, ST_VRD: begin
        ram_cs = 1'b1;
        ram_oe = 1'b1;
      end
      ST_TURN: ready_st = 1'b0;
      default: ;
    endcase
  end

  // rst gates ready so nothing can be accepted while the block is held in reset.
  assign req_ready = ready_st & ~rst;
  assign accept    = req_valid & req_ready;
  assign from_rd   = (state_q == ST_RD) || (state_q == ST_VRD);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = (state_q == ST_RD);
    case (state_q)
      ST_TURN: state_d = ST_WR;
`ifdef SRAM_BUS_MASTER_VERIFY_EN
      ST_WR:   state_d = ST_VRD;
`endif
      default: begin
        if (!accept)      state_d = ST_IDLE;
        else if (!req_we) state_d = ST_RD;
        else if (from_rd) state_d = ST_TURN;  // let the RAM release the bus first
        else              state_d = ST_WR;
      end
    endcase
    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
  end

  assign ram_addr  = addr_q;
  assign rsp_valid = rsp_valid_q;

`ifdef SRAM_BUS_MASTER_VERIFY_EN
  logic [DATA_WIDTH-1:0] bus_din;
  logic                  err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == ST_VRD && bus_din != wdata_q) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign wr_err = err_q;
`else
  assign wr_err = 1'b0;
`endif

  sram_bus_io #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_io (
    .clk        (clk),
    .rst        (rst),
    .drive_en_i (state_q == ST_WR),
    .dout_i     (wdata_q),
    .cap_en_i   (state_q == ST_RD),
`ifdef SRAM_BUS_MASTER_VERIFY_EN
    .din_o      (bus_din),
`endif
    .din_q_o    (rsp_rdata),
    .ram_data   (ram_data)
  );

endmodule

// File: tb/tb_sram_bus_master.sv
// Scoreboard bench for sram_bus_master with a behavioural tristate SRAM.
module tb_sram_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        wr_err;
  logic [3:0]  ram_addr;
  wire  [15:0] ram_data;
  logic        ram_cs, ram_we, ram_oe;

  always #5 clk = ~clk;

  sram_bus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_err(wr_err),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  // RAM model: writes on rising edge, read data latched at falling edge.
  logic [15:0] mem [16];
  logic [15:0] rd_lat = '0;
  logic [15:0] corrupt = '0;
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
  always @(negedge clk) if (ram_cs && ram_oe) rd_lat <= mem[ram_addr] ^ corrupt;
  assign ram_data = (ram_cs && ram_oe) ? rd_lat : 16'hzzzz;

  typedef struct { logic [15:0] d; int cyc; } exp_t;
  exp_t        sb[$];
  logic [15:0] model [16];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int overlap = 0, turn_cnt = 0, stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: pops expectations on every response pulse.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data", {16'd0, rsp_rdata}, {16'd0, e.d});
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
    if (!rst) begin
      if (ram_we && ram_oe) overlap++;
      if (!req_ready && !ram_cs) turn_cnt++;
      if (req_valid && !req_ready) stall++;
    end
  end

  task automatic req(input logic we, input logic [3:0] a, input logic [15:0] d);
    logic rdy, got;
    got = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin got = 1'b1; break; end
    end
    #1;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL req_timeout addr=%0h got=no-accept exp=accept", a);
    end else if (we) model[a] = d;
    else sb.push_back('{model[a], cyc + 1});
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
    @(posedge clk); #1;
  endtask

  int t0;

  initial begin
    for (int i = 0; i < 16; i++) model[i] = '0;
    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rdata", {16'd0, rsp_rdata}, 0);
    chk("rst_wr_err", {31'd0, wr_err}, 0);
    chk("rst_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 0);
    chk("rst_addr", {28'd0, ram_addr}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 1);
    @(posedge clk); #1;

    // 2: single write then read
    req(1'b1, 4'h3, 16'hBEEF);
    req(1'b0, 4'h3, 16'h0);
    idle(3);

    // 3: streaming writes then reads
    t0 = stall;
    for (int a = 0; a < 16; a++) req(1'b1, a[3:0], 16'(a * 16'h1111));
    for (int a = 0; a < 16; a++) req(1'b0, a[3:0], 16'h0);
    idle(4);
`ifndef SRAM_BUS_MASTER_VERIFY_EN
    chk("no_stall", stall - t0, 0);
`endif

    // 4: read -> write turnaround
    t0 = turn_cnt;
    req(1'b0, 4'h5, 16'h0);
    req(1'b1, 4'h6, 16'hA5A6);
    idle(4);
    chk("turn_cycles", turn_cnt - t0, 1);
    req(1'b0, 4'h6, 16'h0);
    idle(3);

    // 5: reset during RD
    req(1'b0, 4'h5, 16'h0);
    req_valid = 1'b0;
    rst = 1'b1;
    void'(sb.pop_back());
    #1 chk("cs_async_drop", {31'd0, ram_cs}, 0);
    @(negedge clk) chk("rst_no_rsp0", {31'd0, rsp_valid}, 0);
    @(negedge clk) chk("rst_no_rsp1", {31'd0, rsp_valid}, 0);
    @(posedge clk); #1 rst = 1'b0;
    req(1'b0, 4'h5, 16'h0);
    req(1'b0, 4'h3, 16'h0);
    idle(3);

    // 6: write-verify
`ifdef SRAM_BUS_MASTER_VERIFY_EN
    chk("wr_err_clean", {31'd0, wr_err}, 0);
    corrupt = 16'h0010;
    req(1'b1, 4'h9, 16'h1234);
    idle(3);
    corrupt = 16'h0000;
    chk("wr_err_set", {31'd0, wr_err}, 1);
    req(1'b1, 4'hA, 16'h4321);
    idle(3);
    chk("wr_err_sticky", {31'd0, wr_err}, 1);
`else
    chk("wr_err_tied", {31'd0, wr_err}, 0);
`endif

    chk("we_oe_overlap", overlap, 0);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
